// File: rtl/pckg_unpack_if.sv
`timescale 1ns/1ps
// Receive-side bus bundle for pckg_unpack: packet input from the LVDS receiver
// and the three downstream FIFO write ports with their full flags.
interface pckg_unpack_if;
    logic        rx_ena;
    logic [23:0] rx_data;
    logic        full_ch1;
    logic        full_ch2;
    logic        full_ch3;
    logic        wr_en_ch1;
    logic        wr_en_ch2;
    logic        wr_en_ch3;
    logic [7:0]  data_ch1;
    logic [7:0]  data_ch2;
    logic [7:0]  data_ch3;

    modport master (
        output rx_ena, rx_data, full_ch1, full_ch2, full_ch3,
        input  wr_en_ch1, wr_en_ch2, wr_en_ch3, data_ch1, data_ch2, data_ch3
    );

    modport slave (
        input  rx_ena, rx_data, full_ch1, full_ch2, full_ch3,
        output wr_en_ch1, wr_en_ch2, wr_en_ch3, data_ch1, data_ch2, data_ch3
    );
endinterface

// File: rtl/pckg_unpack.sv
`timescale 1ns/1ps
// Packet disassembler: validates 24-bit receiver words and routes the payload byte
// to one of three FIFO write ports, keeping saturating error/sequence/drop statistics.
module pckg_unpack (
    input  logic         clk,
    input  logic         rst,
    pckg_unpack_if.slave bus,
    output logic [7:0]   err_cnt,
    output logic [7:0]   seq_err_cnt,
    output logic [7:0]   drop_cnt,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [23:0] pkt_r;
    logic [2:0]  seq_vld_r;
    logic [5:0]  exp_seq_r [0:2];

    logic [2:0]  ch_oh_s;
    logic        tgt_full_s;
    logic        tgt_vld_s;
    logic [5:0]  tgt_exp_s;
    logic        err_inc_s;
    logic        seq_inc_s;
    logic        full_drop_s;
    logic        ovr_drop_s;
    logic        seq_upd_s;
    logic [2:0]  wr_sel_s;

    // Channel 00 is reserved; the check byte is the XOR of header and payload bytes.
    function automatic logic pkt_ok(input logic [23:0] pkt);
        return (pkt[23:22] != 2'b00) && (pkt[7:0] == (pkt[23:16] ^ pkt[15:8]));
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        if (sum > 9'd255) begin
            return 8'hFF;
        end else begin
            return sum[7:0];
        end
    endfunction

    // Decode the in-flight packet's channel into a one-hot select and its per-channel state
    always_comb begin
        ch_oh_s    = 3'b000;
        tgt_full_s = 1'b0;
        tgt_vld_s  = 1'b0;
        tgt_exp_s  = 6'd0;
        case (pkt_r[23:22])
            2'b01: begin
                ch_oh_s    = 3'b001;
                tgt_full_s = bus.full_ch1;
                tgt_vld_s  = seq_vld_r[0];
                tgt_exp_s  = exp_seq_r[0];
            end
            2'b10: begin
                ch_oh_s    = 3'b010;
                tgt_full_s = bus.full_ch2;
                tgt_vld_s  = seq_vld_r[1];
                tgt_exp_s  = exp_seq_r[1];
            end
            2'b11: begin
                ch_oh_s    = 3'b100;
                tgt_full_s = bus.full_ch3;
                tgt_vld_s  = seq_vld_r[2];
                tgt_exp_s  = exp_seq_r[2];
            end
            default: begin
                ch_oh_s    = 3'b000;
                tgt_full_s = 1'b0;
                tgt_vld_s  = 1'b0;
                tgt_exp_s  = 6'd0;
            end
        endcase
    end

    // Next-state logic and per-cycle event flags
    always_comb begin
        state_s     = state_r;
        err_inc_s   = 1'b0;
        seq_inc_s   = 1'b0;
        full_drop_s = 1'b0;
        ovr_drop_s  = 1'b0;
        seq_upd_s   = 1'b0;
        wr_sel_s    = 3'b000;
        case (state_r)
            IDLE: begin
                if (bus.rx_ena) begin
                    state_s = CHECK;
                end else begin
                    state_s = IDLE;
                end
            end
            CHECK: begin
                ovr_drop_s = bus.rx_ena;
                if (!pkt_ok(pkt_r)) begin
                    err_inc_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s   = WRITE;
                end
            end
            WRITE: begin
                ovr_drop_s = bus.rx_ena;
                seq_upd_s  = 1'b1;
                if (tgt_vld_s && (pkt_r[21:16] != tgt_exp_s)) begin
                    seq_inc_s = 1'b1;
                end else begin
                    seq_inc_s = 1'b0;
                end
                // A full FIFO costs the byte but the sequence tracker still advances.
                if (tgt_full_s) begin
                    full_drop_s = 1'b1;
                end else begin
                    wr_sel_s = ch_oh_s;
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and packet capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            pkt_r   <= 24'd0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
            if ((state_r == IDLE) && bus.rx_ena) begin
                pkt_r <= bus.rx_data;
            end
        end
    end

    // Per-channel sequence tracking; any accepted packet resyncs its channel
    always_ff @(posedge clk) begin
        if (rst) begin
            seq_vld_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                exp_seq_r[i] <= 6'd0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (seq_upd_s && ch_oh_s[i]) begin
                    seq_vld_r[i] <= 1'b1;
                    exp_seq_r[i] <= pkt_r[21:16] + 6'd1;
                end
            end
        end
    end

    // Saturating statistics; full drop and overrun can land together
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt     <= 8'd0;
            seq_err_cnt <= 8'd0;
            drop_cnt    <= 8'd0;
        end else begin
            err_cnt     <= sat_add(err_cnt, {1'b0, err_inc_s});
            seq_err_cnt <= sat_add(seq_err_cnt, {1'b0, seq_inc_s});
            drop_cnt    <= sat_add(drop_cnt, {1'b0, full_drop_s} + {1'b0, ovr_drop_s});
        end
    end

    // Registered write strobes; data holds its last value between strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.wr_en_ch1 <= 1'b0;
            bus.wr_en_ch2 <= 1'b0;
            bus.wr_en_ch3 <= 1'b0;
            bus.data_ch1  <= 8'd0;
            bus.data_ch2  <= 8'd0;
            bus.data_ch3  <= 8'd0;
        end else begin
            bus.wr_en_ch1 <= wr_sel_s[0];
            bus.wr_en_ch2 <= wr_sel_s[1];
            bus.wr_en_ch3 <= wr_sel_s[2];
            if (wr_sel_s[0]) begin
                bus.data_ch1 <= pkt_r[15:8];
            end
            if (wr_sel_s[1]) begin
                bus.data_ch2 <= pkt_r[15:8];
            end
            if (wr_sel_s[2]) begin
                bus.data_ch3 <= pkt_r[15:8];
            end
        end
    end

endmodule

// File: tb/tb_pckg_unpack.sv
`timescale 1ns/1ps
// Scoreboard bench for pckg_unpack: a driver issues packets and predicts the outcome
// from the packet rules; an independent monitor pops expectations on every strobe.
module tb_pckg_unpack;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] err_cnt;
    logic [7:0] seq_err_cnt;
    logic [7:0] drop_cnt;
    logic       busy;

    pckg_unpack_if bus ();

    pckg_unpack dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_cnt     (err_cnt),
        .seq_err_cnt (seq_err_cnt),
        .drop_cnt    (drop_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         m_err = 0;
    int         m_seq = 0;
    int         m_drop = 0;
    bit         m_vld [0:3];
    int         m_exp [0:3];
    logic [7:0] m_last [0:3];
    logic [2:0] mon_st;
    int         mon_ch;
    logic [7:0] mon_data;
    exp_t       mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat(input int v, input int inc);
        return (v + inc > 255) ? 255 : v + inc;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_err = 0;
        m_seq = 0;
        m_drop = 0;
        for (int i = 0; i < 4; i++) begin
            m_vld[i]  = 1'b0;
            m_exp[i]  = 0;
            m_last[i] = 8'd0;
        end
        sb_q.delete();
    endtask

    task automatic set_full(input bit f1, input bit f2, input bit f3);
        @(negedge clk);
        bus.full_ch1 = f1;
        bus.full_ch2 = f2;
        bus.full_ch3 = f3;
    endtask

    function automatic bit full_of(input int ch);
        case (ch)
            1: return bus.full_ch1;
            2: return bus.full_ch2;
            3: return bus.full_ch3;
            default: return 1'b0;
        endcase
    endfunction

    // Send one packet, optionally with a corrupt check byte and/or a back-to-back overrun strobe.
    task automatic send(input int ch, input int seq, input logic [7:0] pay, input bit bad, input bit ovr);
        logic [7:0]  hdr;
        logic [23:0] w;
        int          due;
        hdr = {ch[1:0], seq[5:0]};
        w   = {hdr, pay, hdr ^ pay};
        if (bad) w[7:0] = w[7:0] ^ 8'h5A;
        @(negedge clk);
        bus.rx_ena  = 1'b1;
        bus.rx_data = w;
        @(posedge clk);
        #1;
        due = cyc + 2;
        chk("busy_after_accept", busy, 1);
        if (ovr) begin
            bus.rx_data = 24'($urandom);
            @(posedge clk);
            #1;
        end
        bus.rx_ena = 1'b0;
        if (ch == 0 || bad) begin
            m_err = sat(m_err, 1);
        end else begin
            if (m_vld[ch] && seq != m_exp[ch]) m_seq = sat(m_seq, 1);
            m_exp[ch] = (seq + 1) % 64;
            m_vld[ch] = 1'b1;
            if (full_of(ch)) m_drop = sat(m_drop, 1);
            else sb_q.push_back('{ch, pay, due});
        end
        if (ovr) m_drop = sat(m_drop, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_cnts(input string tag);
        chk({tag, ".err_cnt"}, err_cnt, m_err);
        chk({tag, ".seq_err_cnt"}, seq_err_cnt, m_seq);
        chk({tag, ".drop_cnt"}, drop_cnt, m_drop);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".data_ch1"}, bus.data_ch1, m_last[1]);
        chk({tag, ".data_ch2"}, bus.data_ch2, m_last[2]);
        chk({tag, ".data_ch3"}, bus.data_ch3, m_last[3]);
    endtask

    // Monitor: every strobe must match the oldest expectation, at its due cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_st = {bus.wr_en_ch3, bus.wr_en_ch2, bus.wr_en_ch1};
            if ($countones(mon_st) > 1) begin
                checks++;
                errors++;
                $display("FAIL strobe_onehot: got %b expected at most one bit", mon_st);
            end else if (mon_st != 3'b000) begin
                mon_ch   = (mon_st == 3'b001) ? 1 : (mon_st == 3'b010) ? 2 : 3;
                mon_data = (mon_ch == 1) ? bus.data_ch1 : (mon_ch == 2) ? bus.data_ch2 : bus.data_ch3;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_unexpected: got strobe on ch%0d expected none", mon_ch);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("strobe_channel", mon_ch, mon_e.ch);
                    chk("strobe_data", mon_data, mon_e.data);
                    chk("strobe_cycle", cyc, mon_e.due);
                    m_last[mon_e.ch] = mon_e.data;
                end
            end
            if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
                mon_e = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL strobe_missing: got no strobe expected ch%0d data %02h at cycle %0d",
                         mon_e.ch, mon_e.data, mon_e.due);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ch;
        int seq;
        model_reset();
        rst          = 1'b1;
        bus.rx_ena   = 1'b0;
        bus.rx_data  = 24'd0;
        bus.full_ch1 = 1'b0;
        bus.full_ch2 = 1'b0;
        bus.full_ch3 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.wr_en", {bus.wr_en_ch3, bus.wr_en_ch2, bus.wr_en_ch1}, 0);
        check_cnts("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic routing: 0x41A5E4 on ch1
        send(1, 1, 8'hA5, 1'b0, 1'b0);
        check_cnts("route");

        // Sequence checking on ch3, including the 63 -> 0 wrap
        send(3, 5, 8'h11, 1'b0, 1'b0);
        send(3, 6, 8'h22, 1'b0, 1'b0);
        check_cnts("seq_ok");
        send(3, 9, 8'h33, 1'b0, 1'b0);
        check_cnts("seq_gap");
        send(3, 10, 8'h44, 1'b0, 1'b0);
        check_cnts("seq_resync");
        send(3, 63, 8'h55, 1'b0, 1'b0);
        send(3, 0, 8'h66, 1'b0, 1'b0);
        check_cnts("seq_wrap");

        // Bad packets
        send(1, 2, 8'h77, 1'b1, 1'b0);
        check_cnts("bad_check");
        send(0, 4, 8'h88, 1'b0, 1'b0);
        check_cnts("bad_chan");

        // Full output on ch2, then recovery with the following sequence number
        set_full(1'b0, 1'b1, 1'b0);
        send(2, 3, 8'h99, 1'b0, 1'b0);
        check_cnts("full_drop");
        set_full(1'b0, 1'b0, 1'b0);
        send(2, 4, 8'hAA, 1'b0, 1'b0);
        check_cnts("full_release");

        // Overrun: rx_ena on two consecutive cycles
        send(1, 2, 8'h3C, 1'b0, 1'b1);
        check_cnts("overrun");

        // Reset asserted during the WRITE cycle of an in-flight ch2 packet
        @(negedge clk);
        bus.rx_ena  = 1'b1;
        bus.rx_data = {2'b10, 6'd30, 8'hBB, {2'b10, 6'd30} ^ 8'hBB};
        @(posedge clk);
        #1;
        bus.rx_ena = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_mid.wr_en", {bus.wr_en_ch3, bus.wr_en_ch2, bus.wr_en_ch1}, 0);
        check_cnts("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        send(2, 17, 8'hCD, 1'b0, 1'b0);
        check_cnts("post_reset");

        // Randomized traffic against the packet-rule model
        for (int n = 0; n < 150; n++) begin
            set_full($urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            ch  = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 3);
            seq = (m_vld[ch] && $urandom_range(0, 3) != 0) ? m_exp[ch] : $urandom_range(0, 63);
            send(ch, seq, 8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
            check_cnts("random");
        end
        set_full(1'b0, 1'b0, 1'b0);

        // err_cnt saturation
        for (int n = 0; n < 300; n++) begin
            send(1, n % 64, 8'($urandom), 1'b1, 1'b0);
        end
        check_cnts("saturate");
        chk("saturate.err_is_255", err_cnt, 255);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
